// File: rtl/execute_stage_if.sv
// execute_stage_if
//   Bundles the execute stage's pipeline-facing signals:
//   - E-register inputs: e_status, e_icode, e_ifun, e_rA, e_rB,
//     e_valC, e_valP, e_valA and e_valB.
//   - Hazard-unit controls: cc_inhibit and M_bubble.
//   - Forwarding outputs: E_valE, E_dstE and E_Cnd.
//   - M-register outputs: M_status, M_icode, M_Cnd, M_valE, M_valA,
//     M_dstE and M_dstM.
//   - cc_out, the current {ZF,SF,OF}.
//   The master modport drives the E-register side and the hazard
//   controls. The slave modport is the execute stage itself.
interface execute_stage_if #(
  parameter int WIDTH = 64
);
  logic [2:0]       e_status;
  logic [3:0]       e_icode;
  logic [3:0]       e_ifun;
  logic [3:0]       e_rA;
  logic [3:0]       e_rB;
  logic [WIDTH-1:0] e_valC;
  logic [WIDTH-1:0] e_valP;
  logic [WIDTH-1:0] e_valA;
  logic [WIDTH-1:0] e_valB;
  logic             cc_inhibit;
  logic             M_bubble;

  logic [WIDTH-1:0] E_valE;
  logic [3:0]       E_dstE;
  logic             E_Cnd;
  logic [2:0]       M_status;
  logic [3:0]       M_icode;
  logic             M_Cnd;
  logic [WIDTH-1:0] M_valE;
  logic [WIDTH-1:0] M_valA;
  logic [3:0]       M_dstE;
  logic [3:0]       M_dstM;
  logic [2:0]       cc_out;

  modport master (
    output e_status, e_icode, e_ifun, e_rA, e_rB, e_valC, e_valP, e_valA, e_valB,
           cc_inhibit, M_bubble,
    input  E_valE, E_dstE, E_Cnd, M_status, M_icode, M_Cnd, M_valE, M_valA,
           M_dstE, M_dstM, cc_out
  );

  modport slave (
    input  e_status, e_icode, e_ifun, e_rA, e_rB, e_valC, e_valP, e_valA, e_valB,
           cc_inhibit, M_bubble,
    output E_valE, E_dstE, E_Cnd, M_status, M_icode, M_Cnd, M_valE, M_valA,
           M_dstE, M_dstM, cc_out
  );
endinterface

// File: rtl/execute_stage.sv
// execute_stage
//   Execute stage of the Y86-64 pipeline.
//   - Builds the ALU operands from the E register and computes valE.
//   - Holds the condition-code register {ZF,SF,OF}.
//   - Evaluates the cmovXX/jXX condition.
//   - Loads the M pipeline register.
//   Ports:
//   - CLK: clock. All state changes on its rising edge.
//   - RST: synchronous, active-high reset.
//   - ex:  execute_stage_if slave modport.
//     - Inputs: the E-register fields and the hazard controls.
//     - Outputs: combinational forwarding (E_*), the registered M
//       fields (M_*) and cc_out.
//   Latency: e_* reaches M_* one cycle later; E_* has zero latency.
module execute_stage #(
  parameter int         WIDTH = 64,
  parameter logic [3:0] RSP   = 4'h4,
  parameter logic [3:0] RNONE = 4'hF
) (
  input logic           CLK,
  input logic           RST,
  execute_stage_if.slave ex
);

  localparam logic [3:0] I_HALT  = 4'h0, I_NOP    = 4'h1, I_RRMOV = 4'h2, I_IRMOV = 4'h3,
                         I_RMMOV = 4'h4, I_MRMOV  = 4'h5, I_OPQ   = 4'h6, I_JXX   = 4'h7,
                         I_CALL  = 4'h8, I_RET    = 4'h9, I_PUSH  = 4'hA, I_POP   = 4'hB;
  localparam logic [2:0] S_AOK   = 3'd1;
  localparam logic [2:0] CC_RST  = 3'b100;
  localparam logic [WIDTH-1:0] EIGHT = WIDTH'(8);
  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_XOR} alu_op_e;

  logic [2:0]       cc_reg;
  logic [2:0]       cc_next;
  logic [WIDTH-1:0] alu_a, alu_b, alu_r;
  alu_op_e          alu_op;
  logic             zf_new, sf_new, of_new;
  logic             icode_valid;
  logic             cnd;
  logic [3:0]       dst_e_raw, dst_e, dst_m;
  logic             cc_zf, cc_sf, cc_of;

  // valP is carried by the E register but has no use in this stage.
  logic unused_valp;
  assign unused_valp = ^ex.e_valP;

  assign icode_valid = (ex.e_icode <= I_POP);
  assign {cc_zf, cc_sf, cc_of} = cc_reg;

  // Operand selection. Unlisted icodes give 0 + 0, so valE is 0 for
  // halt, nop, jXX and undefined icodes without any extra masking.
  always_comb begin
    alu_a = '0;
    alu_b = '0;
    case (ex.e_icode)
      I_RRMOV, I_OPQ:          alu_a = ex.e_valA;
      I_IRMOV, I_RMMOV, I_MRMOV: alu_a = ex.e_valC;
      I_CALL, I_PUSH:          alu_a = '0 - EIGHT;
      I_RET, I_POP:            alu_a = EIGHT;
      default:                 alu_a = '0;
    endcase
    case (ex.e_icode)
      I_RMMOV, I_MRMOV, I_OPQ, I_CALL, I_RET, I_PUSH, I_POP: alu_b = ex.e_valB;
      default:                                               alu_b = '0;
    endcase
  end

  // ifun selects the operation only for OPq. An out-of-range OPq
  // function code falls back to add.
  always_comb begin
    alu_op = ALU_ADD;
    if (ex.e_icode == I_OPQ) begin
      case (ex.e_ifun)
        4'h1:    alu_op = ALU_SUB;
        4'h2:    alu_op = ALU_AND;
        4'h3:    alu_op = ALU_XOR;
        default: alu_op = ALU_ADD;
      endcase
    end
  end

  always_comb begin
    alu_r  = '0;
    of_new = 1'b0;
    case (alu_op)
      ALU_ADD: begin
        alu_r  = alu_b + alu_a;
        of_new = (alu_a[MSB] == alu_b[MSB]) && (alu_r[MSB] != alu_a[MSB]);
      end
      ALU_SUB: begin
        // Subtraction is valB - valA, so overflow is judged against valB's sign.
        alu_r  = alu_b - alu_a;
        of_new = (alu_a[MSB] != alu_b[MSB]) && (alu_r[MSB] != alu_b[MSB]);
      end
      ALU_AND: alu_r = alu_a & alu_b;
      ALU_XOR: alu_r = alu_a ^ alu_b;
      default: alu_r = '0;
    endcase
    zf_new = (alu_r == '0);
    sf_new = alu_r[MSB];
  end

  // The condition is evaluated from the CC value held before this
  // cycle's update. An OPq therefore never affects its own cmov/jXX.
  always_comb begin
    cnd = 1'b1;
    if (ex.e_icode == I_RRMOV || ex.e_icode == I_JXX) begin
      case (ex.e_ifun)
        4'h0:    cnd = 1'b1;
        4'h1:    cnd = (cc_sf ^ cc_of) | cc_zf;
        4'h2:    cnd = cc_sf ^ cc_of;
        4'h3:    cnd = cc_zf;
        4'h4:    cnd = ~cc_zf;
        4'h5:    cnd = ~(cc_sf ^ cc_of);
        4'h6:    cnd = ~(cc_sf ^ cc_of) & ~cc_zf;
        default: cnd = 1'b0;
      endcase
    end
  end

  always_comb begin
    dst_e_raw = RNONE;
    dst_m     = RNONE;
    case (ex.e_icode)
      I_RRMOV, I_IRMOV, I_OPQ:       dst_e_raw = ex.e_rB;
      I_CALL, I_RET, I_PUSH, I_POP:  dst_e_raw = RSP;
      default:                       dst_e_raw = RNONE;
    endcase
    if (ex.e_icode == I_MRMOV || ex.e_icode == I_POP)
      dst_m = ex.e_rA;
    // A failed cmov squashes its write so that decode never forwards it.
    dst_e = (ex.e_icode == I_RRMOV && !cnd) ? RNONE : dst_e_raw;
  end

  assign ex.E_valE = alu_r;
  assign ex.E_dstE = dst_e;
  assign ex.E_Cnd  = cnd;
  assign ex.cc_out = cc_reg;

  // A bubble only affects the M register, so the CC update ignores M_bubble.
  always_comb begin
    cc_next = cc_reg;
    if (ex.e_icode == I_OPQ && !ex.cc_inhibit && ex.e_status == S_AOK)
      cc_next = {zf_new, sf_new, of_new};
  end

  always_ff @(posedge CLK) begin
    if (RST) cc_reg <= CC_RST;
    else     cc_reg <= cc_next;
  end

  always_ff @(posedge CLK) begin
    if (RST || ex.M_bubble) begin
      ex.M_status <= S_AOK;
      ex.M_icode  <= I_NOP;
      ex.M_Cnd    <= 1'b0;
      ex.M_valE   <= '0;
      ex.M_valA   <= '0;
      ex.M_dstE   <= RNONE;
      ex.M_dstM   <= RNONE;
    end else begin
      ex.M_status <= ex.e_status;
      ex.M_icode  <= ex.e_icode;
      ex.M_Cnd    <= cnd;
      ex.M_valE   <= alu_r;
      ex.M_valA   <= icode_valid ? ex.e_valA : '0;
      ex.M_dstE   <= dst_e;
      ex.M_dstM   <= dst_m;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage
//   Scoreboard bench for execute_stage.
//   - Each transaction drives the E register after a falling edge.
//   - The combinational forwarding outputs are checked right away.
//   - The expected M contents and CC value are queued, then popped and
//     compared one cycle later.
//   - One line is printed per transaction.
module tb_execute_stage;
  localparam int WIDTH = 64;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  execute_stage_if #(.WIDTH(WIDTH)) ex ();
  execute_stage #(.WIDTH(WIDTH), .RSP(4'h4), .RNONE(4'hF)) dut (
    .CLK(CLK),
    .RST(RST),
    .ex (ex.slave)
  );

  typedef struct {
    string       name;
    logic [2:0]  status;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] val_e;
    logic [63:0] val_a;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic [2:0]  cc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Fields: rst, bub, inh, status, icode, ifun, rA, rB, valC, valA, valB.
  // Expected: chk_comb, valE, dstE, Cnd, dstM, cc after the edge.
  task automatic txn(input string name, input logic rst, input logic bub, input logic inh,
                     input logic [2:0] st, input logic [3:0] ic, input logic [3:0] fn,
                     input logic [3:0] ra, input logic [3:0] rb, input logic [63:0] vc,
                     input logic [63:0] va, input logic [63:0] vb,
                     input logic chk_comb, input logic [63:0] x_vale, input logic [3:0] x_dste,
                     input logic x_cnd, input logic [3:0] x_dstm, input logic [2:0] x_cc);
    exp_t e;
    @(negedge CLK);
    RST = rst;
    ex.M_bubble = bub;
    ex.cc_inhibit = inh;
    ex.e_status = st;
    ex.e_icode = ic;
    ex.e_ifun = fn;
    ex.e_rA = ra;
    ex.e_rB = rb;
    ex.e_valC = vc;
    ex.e_valP = 64'h1000;
    ex.e_valA = va;
    ex.e_valB = vb;
    #1;
    if (chk_comb) begin
      check_val({name, ".E_valE"}, ex.E_valE, x_vale);
      check_val({name, ".E_dstE"}, {60'd0, ex.E_dstE}, {60'd0, x_dste});
      check_val({name, ".E_Cnd"}, {63'd0, ex.E_Cnd}, {63'd0, x_cnd});
    end
    e.name = name;
    e.cc = x_cc;
    if (rst || bub) begin
      e.status = 3'd1; e.icode = 4'h1; e.cnd = 1'b0; e.val_e = '0; e.val_a = '0;
      e.dst_e = 4'hF; e.dst_m = 4'hF;
    end else begin
      e.status = st; e.icode = ic; e.cnd = x_cnd; e.val_e = x_vale; e.val_a = va;
      e.dst_e = x_dste; e.dst_m = x_dstm;
    end
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
    if (exp_q.size() == 0) begin
      check_val({name, ".queue"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      check_val({e.name, ".M_status"}, {61'd0, ex.M_status}, {61'd0, e.status});
      check_val({e.name, ".M_icode"}, {60'd0, ex.M_icode}, {60'd0, e.icode});
      check_val({e.name, ".M_Cnd"}, {63'd0, ex.M_Cnd}, {63'd0, e.cnd});
      check_val({e.name, ".M_valE"}, ex.M_valE, e.val_e);
      check_val({e.name, ".M_valA"}, ex.M_valA, e.val_a);
      check_val({e.name, ".M_dstE"}, {60'd0, ex.M_dstE}, {60'd0, e.dst_e});
      check_val({e.name, ".M_dstM"}, {60'd0, ex.M_dstM}, {60'd0, e.dst_m});
      check_val({e.name, ".cc_out"}, {61'd0, ex.cc_out}, {61'd0, e.cc});
    end
    $display("txn %-14s icode=%h valE=%h M_icode=%h cc=%b", name, ic, ex.M_valE, ex.M_icode, ex.cc_out);
  endtask

  localparam logic [63:0] Q = 64'h4000_0000_0000_0000;
  localparam logic [63:0] H = 64'h8000_0000_0000_0000;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ex.M_bubble = 1'b0; ex.cc_inhibit = 1'b0; ex.e_status = 3'd1; ex.e_icode = 4'h1;
    ex.e_ifun = 4'h0; ex.e_rA = 4'hF; ex.e_rB = 4'hF; ex.e_valC = '0; ex.e_valP = '0;
    ex.e_valA = '0; ex.e_valB = '0;
    //   name            rst bub inh st   ic    fn    rA    rB    valC   valA         valB          cc?  valE                     dstE  Cnd   dstM  cc
    txn("reset",          1, 0, 0, 3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0,       64'd0,         0, 64'd0,                   4'hF, 1'b1, 4'hF, 3'b100);
    txn("add_ovf",        0, 0, 0, 3'd1, 4'h6, 4'h0, 4'h2, 4'h3, 64'd0, Q,           Q,             1, H,                       4'h3, 1'b1, 4'hF, 3'b011);
    txn("sub_zero",       0, 0, 0, 3'd1, 4'h6, 4'h1, 4'h2, 4'h3, 64'd0, 64'd5,       64'd5,         1, 64'd0,                   4'h3, 1'b1, 4'hF, 3'b100);
    txn("sub_inhibit",    0, 0, 1, 3'd1, 4'h6, 4'h1, 4'h2, 4'h3, 64'd0, 64'd5,       64'd7,         1, 64'd2,                   4'h3, 1'b1, 4'hF, 3'b100);
    txn("add_ovf2",       0, 0, 0, 3'd1, 4'h6, 4'h0, 4'h2, 4'h3, 64'd0, Q,           Q,             1, H,                       4'h3, 1'b1, 4'hF, 3'b011);
    txn("cmovl_no",       0, 0, 0, 3'd1, 4'h2, 4'h2, 4'h1, 4'h6, 64'd0, 64'h55,      64'd0,         1, 64'h55,                  4'hF, 1'b0, 4'hF, 3'b011);
    txn("sub_neg",        0, 0, 0, 3'd1, 4'h6, 4'h1, 4'h2, 4'h3, 64'd0, 64'd1,       64'd0,         1, 64'hFFFF_FFFF_FFFF_FFFF, 4'h3, 1'b1, 4'hF, 3'b010);
    txn("cmovl_yes",      0, 0, 0, 3'd1, 4'h2, 4'h2, 4'h1, 4'h6, 64'd0, 64'h55,      64'd0,         1, 64'h55,                  4'h6, 1'b1, 4'hF, 3'b010);
    txn("pushq",          0, 0, 0, 3'd1, 4'hA, 4'h0, 4'h2, 4'hF, 64'd0, 64'h1234,    64'h100,       1, 64'hF8,                  4'h4, 1'b1, 4'hF, 3'b010);
    txn("popq",           0, 0, 0, 3'd1, 4'hB, 4'h0, 4'h2, 4'hF, 64'd0, 64'h100,     64'h100,       1, 64'h108,                 4'h4, 1'b1, 4'h2, 3'b010);
    txn("mrmov_bubble",   0, 1, 0, 3'd1, 4'h5, 4'h0, 4'h7, 4'h3, 64'd8, 64'd0,       64'h20,        1, 64'h28,                  4'hF, 1'b1, 4'h7, 3'b010);
    txn("and_bubble",     0, 1, 0, 3'd1, 4'h6, 4'h2, 4'h2, 4'h3, 64'd0, 64'hF0,      64'h0F,        1, 64'd0,                   4'h3, 1'b1, 4'hF, 3'b100);
    txn("xor_inh_bub",    0, 1, 1, 3'd1, 4'h6, 4'h3, 4'h2, 4'h3, 64'd0, 64'h3,       64'h1,         1, 64'h2,                   4'h3, 1'b1, 4'hF, 3'b100);
    txn("mrmovq",         0, 0, 0, 3'd1, 4'h5, 4'h0, 4'h7, 4'h3, 64'd8, 64'd0,       64'h20,        1, 64'h28,                  4'hF, 1'b1, 4'h7, 3'b100);
    txn("add_adr_stat",   0, 0, 0, 3'd3, 4'h6, 4'h0, 4'h2, 4'h3, 64'd0, 64'd1,       64'd1,         1, 64'd2,                   4'h3, 1'b1, 4'hF, 3'b100);
    txn("add_ovf3",       0, 0, 0, 3'd1, 4'h6, 4'h0, 4'h2, 4'h3, 64'd0, Q,           Q,             1, H,                       4'h3, 1'b1, 4'hF, 3'b011);
    txn("rst_with_opq",   1, 0, 0, 3'd1, 4'h6, 4'h0, 4'h2, 4'h3, 64'd0, Q,           Q,             1, H,                       4'h3, 1'b1, 4'hF, 3'b100);
    txn("cmovle_post",    0, 0, 0, 3'd1, 4'h2, 4'h1, 4'h1, 4'h5, 64'd0, 64'h77,      64'd0,         1, 64'h77,                  4'h5, 1'b1, 4'hF, 3'b100);
    txn("jne_post",       0, 0, 0, 3'd1, 4'h7, 4'h4, 4'hF, 4'hF, 64'h40, 64'h99,     64'd0,         1, 64'd0,                   4'hF, 1'b0, 4'hF, 3'b100);
    txn("jmp",            0, 0, 0, 3'd1, 4'h7, 4'h0, 4'hF, 4'hF, 64'h40, 64'h9A,     64'd0,         1, 64'd0,                   4'hF, 1'b1, 4'hF, 3'b100);
    txn("irmovq",         0, 0, 0, 3'd1, 4'h3, 4'h0, 4'hF, 4'h9, 64'hABCD, 64'd0,    64'h5,         1, 64'hABCD,                4'h9, 1'b1, 4'hF, 3'b100);
    check_val("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
